// File: rtl/op_decode_pkg.sv
// Shared definitions for the decode/issue stage.
//   opcode_e     : RV32I major opcodes handled by the integer ALU path
//   f3_op_int_e  : funct3 encodings of the integer register/immediate ops
//   F7_ALT       : funct7 value selecting SUB / SRA
package op_decode_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   typedef enum logic [6:0] {
      OP     = 7'b0110011,
      OP_IMM = 7'b0010011,
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111
   } opcode_e;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_SL   = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SR   = 3'b101,
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } f3_op_int_e;

   localparam logic [6:0] F7_ALT = 7'b0100000;

endpackage

// File: rtl/op_decode_regfile.sv
// 32 x 32 integer register file, x0 hardwired to zero.
//   clk, rst_n      : clock, async active-low reset (clears every register)
//   we, wa, wd      : write port, ignored when wa == 0
//   ra1/rd1, ra2/rd2: combinational read ports; a same-cycle write to the
//                     addressed register is forwarded to the read data
module op_decode_regfile
   import op_decode_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   input  logic [4:0]      ra1,
   output logic [XLEN-1:0] rd1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd2
);

   logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

   always_comb begin
      regs_d = regs_q;
      if (we && (wa != 5'd0)) regs_d[wa] = wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= '0;
      else        regs_q <= regs_d;
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != 5'd0) rd1 = (we && (wa == ra1)) ? wd : regs_q[ra1];
      if (ra2 != 5'd0) rd2 = (we && (wa == ra2)) ? wd : regs_q[ra2];
   end

endmodule

// File: rtl/op_decode.sv
// Decode/issue stage feeding the integer ALU.
//   if_valid/if_ready/if_inst/if_pc : instruction input handshake
//   ex_valid/ex_ready/ex_*          : registered operand bundle for the ALU
//   wb_we/wb_rd/wb_data             : writeback port (regfile + scoreboard clear)
//   illegal                         : one-cycle pulse after an unsupported opcode
//                                     is accepted and dropped
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds valid and its payload stable until that transfer, and
// ready may depend combinationally on the offered payload (hazard check).
module op_decode
   import op_decode_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_inst,
   input  logic [31:0]     if_pc,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic            ex_op,
   output logic            ex_op_imm,
   output logic [2:0]      ex_funct3,
   output logic [6:0]      ex_funct7,
   output logic [31:0]     ex_a,
   output logic [31:0]     ex_b,
   output logic [4:0]      ex_rd,
   output logic            ex_we,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [31:0]     wb_data,
   output logic            illegal
);

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] rs1_data, rs2_data;

   assign opcode = if_inst[6:0];
   assign rd     = if_inst[11:7];
   assign funct3 = if_inst[14:12];
   assign rs1    = if_inst[19:15];
   assign rs2    = if_inst[24:20];
   assign funct7 = if_inst[31:25];

   op_decode_regfile u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wb_we),
      .wa    (wb_rd),
      .wd    (wb_data),
      .ra1   (rs1),
      .rd1   (rs1_data),
      .ra2   (rs2),
      .rd2   (rs2_data)
   );

   // Decode
   logic        legal, uses_rs1, uses_rs2;
   logic        dec_op, dec_op_imm;
   logic [2:0]  dec_f3;
   logic [6:0]  dec_f7;
   logic [31:0] dec_a, dec_b;

   always_comb begin
      legal      = 1'b1;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      dec_op     = 1'b0;
      dec_op_imm = 1'b0;
      dec_f3     = F3_ADD;
      dec_f7     = 7'd0;
      dec_a      = '0;
      dec_b      = '0;
      case (opcode)
         OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            dec_op   = 1'b1;
            dec_f3   = funct3;
            dec_f7   = funct7;
            dec_a    = rs1_data;
            dec_b    = rs2_data;
         end
         OP_IMM: begin
            uses_rs1   = 1'b1;
            dec_op_imm = 1'b1;
            dec_f3     = funct3;
            // Only shifts carry funct7; forcing 0 elsewhere keeps ADDI with a
            // negative immediate from looking like SUB to the ALU.
            dec_f7     = ((funct3 == F3_SL) || (funct3 == F3_SR)) ? funct7 : 7'd0;
            dec_a      = rs1_data;
            dec_b      = {{20{if_inst[31]}}, if_inst[31:20]};
         end
         LUI: begin
            dec_op_imm = 1'b1;
            dec_b      = {if_inst[31:12], 12'd0};
         end
         AUIPC: begin
            dec_op_imm = 1'b1;
            dec_a      = if_pc;
            dec_b      = {if_inst[31:12], 12'd0};
         end
         default: legal = 1'b0;
      endcase
   end

   // Scoreboard and hazard
   logic [NREGS-1:0] busy_q, busy_d, clr_mask, set_mask, busy_eff;
   logic             hazard, accept, issue;

   always_comb begin
      clr_mask = '0;
      if (wb_we) clr_mask[wb_rd] = 1'b1;
   end

   // A writeback this cycle releases the register for the waiting instruction.
   assign busy_eff = busy_q & ~clr_mask;

   assign hazard = legal & ((uses_rs1 & busy_eff[rs1]) |
                            (uses_rs2 & busy_eff[rs2]) |
                            busy_eff[rd]);

   assign if_ready = (!ex_valid | ex_ready) & !hazard;
   assign accept   = if_valid & if_ready;
   assign issue    = accept & legal;

   always_comb begin
      set_mask = '0;
      if (issue) set_mask[rd] = 1'b1;
      // Set is applied after clear so a same-cycle set/clear leaves it busy.
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   // Output register
   logic        ex_valid_q, ex_valid_d, illegal_q, illegal_d;
   logic        ex_op_q, ex_op_d, ex_op_imm_q, ex_op_imm_d, ex_we_q, ex_we_d;
   logic [2:0]  ex_funct3_q, ex_funct3_d;
   logic [6:0]  ex_funct7_q, ex_funct7_d;
   logic [31:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
   logic [4:0]  ex_rd_q, ex_rd_d;

   always_comb begin
      // accept implies the slot is free, so no pending bundle survives it
      ex_valid_d  = issue | (ex_valid_q & !ex_ready);
      illegal_d   = accept & !legal;
      ex_op_d     = ex_op_q;
      ex_op_imm_d = ex_op_imm_q;
      ex_funct3_d = ex_funct3_q;
      ex_funct7_d = ex_funct7_q;
      ex_a_d      = ex_a_q;
      ex_b_d      = ex_b_q;
      ex_rd_d     = ex_rd_q;
      ex_we_d     = ex_we_q;
      if (issue) begin
         ex_op_d     = dec_op;
         ex_op_imm_d = dec_op_imm;
         ex_funct3_d = dec_f3;
         ex_funct7_d = dec_f7;
         ex_a_d      = dec_a;
         ex_b_d      = dec_b;
         ex_rd_d     = rd;
         ex_we_d     = (rd != 5'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         ex_valid_q  <= 1'b0;
         illegal_q   <= 1'b0;
         ex_op_q     <= 1'b0;
         ex_op_imm_q <= 1'b0;
         ex_funct3_q <= 3'd0;
         ex_funct7_q <= 7'd0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_rd_q     <= 5'd0;
         ex_we_q     <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         ex_valid_q  <= ex_valid_d;
         illegal_q   <= illegal_d;
         ex_op_q     <= ex_op_d;
         ex_op_imm_q <= ex_op_imm_d;
         ex_funct3_q <= ex_funct3_d;
         ex_funct7_q <= ex_funct7_d;
         ex_a_q      <= ex_a_d;
         ex_b_q      <= ex_b_d;
         ex_rd_q     <= ex_rd_d;
         ex_we_q     <= ex_we_d;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign illegal   = illegal_q;
   assign ex_op     = ex_op_q;
   assign ex_op_imm = ex_op_imm_q;
   assign ex_funct3 = ex_funct3_q;
   assign ex_funct7 = ex_funct7_q;
   assign ex_a      = ex_a_q;
   assign ex_b      = ex_b_q;
   assign ex_rd     = ex_rd_q;
   assign ex_we     = ex_we_q;

endmodule

// File: tb/tb_op_decode.sv
module tb_op_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid, if_ready;
   logic [31:0] if_inst, if_pc;
   logic        ex_valid, ex_ready;
   logic        ex_op, ex_op_imm;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;
   logic [31:0] ex_a, ex_b;
   logic [4:0]  ex_rd;
   logic        ex_we;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal;

   int n_chk  = 0;
   int n_fail = 0;

   op_decode dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .if_inst   (if_inst),
      .if_pc     (if_pc),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_op     (ex_op),
      .ex_op_imm (ex_op_imm),
      .ex_funct3 (ex_funct3),
      .ex_funct7 (ex_funct7),
      .ex_a      (ex_a),
      .ex_b      (ex_b),
      .ex_rd     (ex_rd),
      .ex_we     (ex_we),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
      ex_ready = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      #12;
      // reset state
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_illegal",  illegal, 0);
      chk("rst_if_ready", if_ready, 1);
      chk("rst_ex_b",     ex_b, 0);
      chk("rst_ex_rd",    ex_rd, 0);
      rst_n = 1'b1;
      tick();

      // ADDI x1,x0,-5
      if_valid = 1'b1; if_inst = enc_i(12'hFFB, 5'd0, 3'b000, 5'd1);
      settle();
      chk("addi_if_ready", if_ready, 1);
      tick();
      chk("addi_valid",  ex_valid, 1);
      chk("addi_op",     ex_op, 0);
      chk("addi_op_imm", ex_op_imm, 1);
      chk("addi_f3",     ex_funct3, 0);
      chk("addi_f7",     ex_funct7, 0);
      chk("addi_a",      ex_a, 0);
      chk("addi_b",      ex_b, 32'hFFFF_FFFB);
      chk("addi_rd",     ex_rd, 1);
      chk("addi_we",     ex_we, 1);

      // consume, write x1 = 0x80000000
      if_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h8000_0000;
      tick();
      chk("idle_valid", ex_valid, 0);
      wb_we = 1'b0;

      // SRAI x2,x1,3
      if_valid = 1'b1; if_inst = enc_i(12'h403, 5'd1, 3'b101, 5'd2);
      settle();
      chk("srai_if_ready", if_ready, 1);
      tick();
      chk("srai_f7",    ex_funct7, 7'h20);
      chk("srai_shamt", ex_b[4:0], 3);
      chk("srai_a",     ex_a, 32'h8000_0000);
      chk("srai_f3",    ex_funct3, 3'b101);

      // LUI x3,0x12345
      if_inst = enc_u(20'h12345, 5'd3, 7'b0110111);
      tick();
      chk("lui_a",      ex_a, 0);
      chk("lui_b",      ex_b, 32'h1234_5000);
      chk("lui_op_imm", ex_op_imm, 1);

      // AUIPC x4,1 at pc 0x100
      if_inst = enc_u(20'h00001, 5'd4, 7'b0010111); if_pc = 32'h100;
      tick();
      chk("auipc_a",  ex_a, 32'h100);
      chk("auipc_b",  ex_b, 32'h1000);
      chk("auipc_f3", ex_funct3, 0);

      // ADD x5,x1,x2 while x2 is being written back: clear + bypass
      if_inst = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd5);
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd2;
      settle();
      chk("add_bypass_ready", if_ready, 1);
      tick();
      chk("add_op", ex_op, 1);
      chk("add_a",  ex_a, 32'h8000_0000);
      chk("add_b",  ex_b, 2);
      chk("add_rd", ex_rd, 5);
      wb_we = 1'b0;

      // SUB x6,x5,x1: RAW on x5
      if_inst = enc_r(7'b0100000, 5'd1, 5'd5, 3'b000, 5'd6);
      settle();
      chk("raw_stall", if_ready, 0);
      tick();
      chk("raw_no_issue", ex_valid, 0);
      chk("raw_hold",     if_ready, 0);
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'd77;
      settle();
      chk("raw_release", if_ready, 1);
      tick();
      chk("sub_valid", ex_valid, 1);
      chk("sub_a",     ex_a, 77);
      chk("sub_b",     ex_b, 32'h8000_0000);
      chk("sub_f7",    ex_funct7, 7'h20);
      chk("sub_rd",    ex_rd, 6);
      wb_we = 1'b0;

      // WAW: ADDI x6,x0,1 while x6 is busy
      if_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd6);
      settle();
      chk("waw_stall", if_ready, 0);
      tick();
      chk("waw_no_issue", ex_valid, 0);
      // clear and re-set x6 in the same cycle: set wins
      wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'd9;
      settle();
      chk("waw_release", if_ready, 1);
      tick();
      chk("waw_issue_b", ex_b, 1);
      chk("waw_issue_rd", ex_rd, 6);
      wb_we = 1'b0;
      if_inst = enc_r(7'd0, 5'd0, 5'd6, 3'b000, 5'd7);
      settle();
      chk("set_wins_stall", if_ready, 0);

      // backpressure with LUI x8 offered
      ex_ready = 1'b0; if_inst = enc_u(20'hABCDE, 5'd8, 7'b0110111);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_if_ready", if_ready, 0);
         tick();
         chk("bp_valid", ex_valid, 1);
         chk("bp_b",     ex_b, 1);
         chk("bp_rd",    ex_rd, 6);
      end
      // x8 untouched by the blocked LUI: ADD x9,x8,x0 may issue
      ex_ready = 1'b1; if_inst = enc_r(7'd0, 5'd0, 5'd8, 3'b000, 5'd9);
      settle();
      chk("bp_sb_unchanged", if_ready, 1);
      tick();
      chk("bp_after_rd", ex_rd, 9);
      chk("bp_after_a",  ex_a, 0);

      // illegal opcode with rd=x10
      if_inst = {20'd0, 5'd10, 7'b1111111};
      settle();
      chk("ill_ready", if_ready, 1);
      tick();
      chk("ill_pulse", illegal, 1);
      chk("ill_valid", ex_valid, 0);
      if_valid = 1'b0;
      tick();
      chk("ill_pulse_end", illegal, 0);
      if_valid = 1'b1; if_inst = enc_r(7'd0, 5'd0, 5'd10, 3'b000, 5'd11);
      settle();
      chk("ill_no_busy", if_ready, 1);

      // ADDI x12,x0,5, then stall ADD x11,x6,x0 and reset mid-stall
      if_inst = enc_i(12'd5, 5'd0, 3'b000, 5'd12);
      tick();
      chk("pre_rst_b", ex_b, 5);
      ex_ready = 1'b0; if_inst = enc_r(7'd0, 5'd0, 5'd6, 3'b000, 5'd11);
      settle();
      chk("pre_rst_stall", if_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid",    ex_valid, 0);
      chk("arst_b",        ex_b, 0);
      chk("arst_rd",       ex_rd, 0);
      chk("arst_we",       ex_we, 0);
      chk("arst_op_imm",   ex_op_imm, 0);
      chk("arst_illegal",  illegal, 0);
      chk("arst_if_ready", if_ready, 1);
      tick();
      rst_n = 1'b1; ex_ready = 1'b1;
      tick();
      chk("post_rst_valid", ex_valid, 1);
      chk("post_rst_a",     ex_a, 0);
      chk("post_rst_rd",    ex_rd, 11);

      if_valid = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
